hilo_unit: RTL and testbench

HILO_UNIT -- requirements
Module: hilo_unit

---
 rtl/hilo_pkg.sv | 13 +
 rtl/hilo_unit_if.sv | 27 ++
 rtl/hilo_unit.sv | 58 +++++
 tb/tb_hilo_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// hilo_pkg: shared op-codes, state encoding and decode helper for the HI/LO unit
package hilo_pkg;
   localparam int OP_W = 3;
   localparam logic [OP_W-1:0] OP_NOP  = 3'b000;
   localparam logic [OP_W-1:0] OP_DIV  = 3'b001;
   localparam logic [OP_W-1:0] OP_DIVU = 3'b010;
   localparam logic [OP_W-1:0] OP_MTHI = 3'b011;
   localparam logic [OP_W-1:0] OP_MTLO = 3'b100;
   typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
   function automatic logic is_div(input logic [OP_W-1:0] op);
      return op == OP_DIV || op == OP_DIVU;
   endfunction
endpackage

// File: rtl/hilo_unit_if.sv
// hilo_unit_if: request handshake, HI/LO readout and external divider bus
interface hilo_unit_if;
   import hilo_pkg::*;
   logic            op_valid;
   logic [OP_W-1:0] op_code;
   logic [31:0]     rs_data;
   logic [31:0]     rt_data;
   logic            op_ready;
   logic            done;
   logic            div_by_zero;
   logic [31:0]     hi;
   logic [31:0]     lo;
   logic [31:0]     div_dividend;
   logic [31:0]     div_divisor;
   logic            div_ena;
   logic            div_signed;
   logic [31:0]     div_q;
   logic [31:0]     div_r;
   modport master (
      output op_valid, op_code, rs_data, rt_data, div_q, div_r,
      input  op_ready, done, div_by_zero, hi, lo, div_dividend, div_divisor, div_ena, div_signed
   );
   modport slave (
      input  op_valid, op_code, rs_data, rt_data, div_q, div_r,
      output op_ready, done, div_by_zero, hi, lo, div_dividend, div_divisor, div_ena, div_signed
   );
endinterface

// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register file with MTHI/MTLO and sequencing of an external fixed-latency divider
module hilo_unit
   import hilo_pkg::*;
#(
   parameter int DIV_LATENCY = 4
) (
   input logic        clk,
   input logic        reset,
   hilo_unit_if.slave bus
);
   localparam logic [4:0] CNT_LOAD = 5'(DIV_LATENCY - 1);
   state_t     state, next;
   logic [4:0] cnt;
   logic       accept, start, zdiv, last, mt;
   assign bus.op_ready = state == ST_IDLE;
   assign bus.div_ena  = state == ST_WAIT;
   // request decode and next-state selection
   always_comb begin
      accept = bus.op_valid & bus.op_ready;
      start  = accept & is_div(bus.op_code) & (|bus.rt_data);
      zdiv   = accept & is_div(bus.op_code) & ~(|bus.rt_data);
      mt     = accept & (bus.op_code == OP_MTHI || bus.op_code == OP_MTLO);
      last   = state == ST_WAIT && cnt == '0;
      next   = start ? ST_WAIT : last ? ST_IDLE : state;
   end
   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next;
   end
   // HI/LO, divider operands, status flags and the latency counter
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt              <= '0;
         bus.done         <= 1'b0;
         bus.div_by_zero  <= 1'b0;
         bus.div_signed   <= 1'b0;
         bus.div_dividend <= '0;
         bus.div_divisor  <= '0;
         bus.hi           <= '0;
         bus.lo           <= '0;
      end else begin
         cnt      <= start ? CNT_LOAD : (state == ST_WAIT && cnt != '0) ? cnt - 5'd1 : cnt;
         bus.done <= mt | zdiv | last;
         if (start) begin
            bus.div_dividend <= bus.rs_data;
            bus.div_divisor  <= bus.rt_data;
            bus.div_signed   <= bus.op_code == OP_DIV;
            bus.div_by_zero  <= 1'b0;
         end
         if (zdiv) bus.div_by_zero <= 1'b1;
         if (accept && bus.op_code == OP_MTHI) bus.hi <= bus.rs_data;
         else if (last)                        bus.hi <= bus.div_r;
         if (accept && bus.op_code == OP_MTLO) bus.lo <= bus.rs_data;
         else if (last)                        bus.lo <= bus.div_q;
      end
   end
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed vector table plus hand-written multi-cycle sequences for hilo_unit
module tb_hilo_unit;
   import hilo_pkg::*;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   always #5 clk = ~clk;
   hilo_unit_if b4();
   hilo_unit_if b1();
   hilo_unit #(.DIV_LATENCY(4)) dut4 (.clk(clk), .reset(reset), .bus(b4.slave));
   hilo_unit #(.DIV_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
   function automatic logic [63:0] divm(input logic s, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'h0) return 64'h0;
      if (s && a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h80000000, 32'h0};
      if (s) return {32'($signed(a) / $signed(b)), 32'($signed(a) % $signed(b))};
      return {a / b, a % b};
   endfunction
   assign {b4.div_q, b4.div_r} = divm(b4.div_signed, b4.div_dividend, b4.div_divisor);
   assign {b1.div_q, b1.div_r} = divm(b1.div_signed, b1.div_dividend, b1.div_divisor);
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   typedef struct {
      logic [2:0]  op;
      logic [31:0] rs, rt, hi, lo;
      logic        dbz, sgn;
      int          done_at, ena;
   } vec_t;
   vec_t vt[12];
   task automatic run4(input vec_t v, output int first, output int nd, output int ne, output int bad);
      first = 0; nd = 0; ne = 0; bad = 0;
      @(negedge clk);
      b4.op_valid = 1'b1; b4.op_code = v.op; b4.rs_data = v.rs; b4.rt_data = v.rt;
      @(posedge clk);
      #1 b4.op_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (b4.done) begin
            nd++;
            if (first == 0) first = k;
         end
         if (b4.div_ena) begin
            ne++;
            if (b4.div_dividend !== v.rs || b4.div_divisor !== v.rt) bad++;
         end
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
   initial begin
      int first, nd, ne, bad;
      vt[0]  = '{OP_MTHI, 32'h12345678, 32'h0,        32'h12345678, 32'h0,        1'b0, 1'b0, 1, 0};
      vt[1]  = '{OP_DIV,  32'h7,        32'h0,        32'h12345678, 32'h0,        1'b1, 1'b0, 1, 0};
      vt[2]  = '{OP_MTLO, 32'hCAFEF00D, 32'h0,        32'h12345678, 32'hCAFEF00D, 1'b1, 1'b0, 1, 0};
      vt[3]  = '{OP_DIV,  32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1'b0, 1'b1, 5, 4};
      vt[4]  = '{OP_DIVU, 32'hFFFFFFFF, 32'h10,       32'hF,        32'h0FFFFFFF, 1'b0, 1'b0, 5, 4};
      vt[5]  = '{OP_NOP,  32'hDEADBEEF, 32'h5,        32'hF,        32'h0FFFFFFF, 1'b0, 1'b0, 0, 0};
      vt[6]  = '{3'b111,  32'hDEADBEEF, 32'h5,        32'hF,        32'h0FFFFFFF, 1'b0, 1'b0, 0, 0};
      vt[7]  = '{3'b101,  32'h1234,     32'h0,        32'hF,        32'h0FFFFFFF, 1'b0, 1'b0, 0, 0};
      vt[8]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 1'b1, 5, 4};
      vt[9]  = '{OP_DIV,  32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1, 5, 4};
      vt[10] = '{OP_DIVU, 32'h0,        32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 1'b1, 1, 0};
      vt[11] = '{OP_DIVU, 32'h64,       32'h7,        32'h2,        32'hE,        1'b0, 1'b0, 5, 4};
      b1.op_valid = 1'b0; b1.op_code = OP_NOP; b1.rs_data = '0; b1.rt_data = '0;
      b4.op_valid = 1'b1; b4.op_code = OP_MTHI; b4.rs_data = 32'hFFFF0000; b4.rt_data = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0; b4.op_valid = 1'b0;
      @(negedge clk);
      chk("rst_hi", b4.hi, 32'h0);
      chk("rst_lo", b4.lo, 32'h0);
      chk("rst_done", 32'(b4.done), 32'h0);
      chk("rst_dbz", 32'(b4.div_by_zero), 32'h0);
      chk("rst_ena", 32'(b4.div_ena), 32'h0);
      chk("rst_sgn", 32'(b4.div_signed), 32'h0);
      chk("rst_dvd", b4.div_dividend, 32'h0);
      chk("rst_dvs", b4.div_divisor, 32'h0);
      chk("rst_ready", 32'(b4.op_ready), 32'h1);
      for (int i = 0; i < 12; i++) begin
         run4(vt[i], first, nd, ne, bad);
         chk($sformatf("v%0d_hi", i), b4.hi, vt[i].hi);
         chk($sformatf("v%0d_lo", i), b4.lo, vt[i].lo);
         chk($sformatf("v%0d_dbz", i), 32'(b4.div_by_zero), 32'(vt[i].dbz));
         chk($sformatf("v%0d_sgn", i), 32'(b4.div_signed), 32'(vt[i].sgn));
         chk($sformatf("v%0d_done_at", i), 32'(first), 32'(vt[i].done_at));
         chk($sformatf("v%0d_ndone", i), 32'(nd), vt[i].done_at != 0 ? 32'h1 : 32'h0);
         chk($sformatf("v%0d_ena_cycles", i), 32'(ne), 32'(vt[i].ena));
         chk($sformatf("v%0d_opnd_stable", i), 32'(bad), 32'h0);
         chk($sformatf("v%0d_ready", i), 32'(b4.op_ready), 32'h1);
      end
      @(negedge clk);
      b4.op_valid = 1'b1; b4.op_code = OP_DIV; b4.rs_data = 32'd1000; b4.rt_data = 32'd7;
      @(posedge clk);
      #1 b4.op_code = OP_MTLO; b4.rs_data = 32'hA5A5A5A5;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("hold_ready_%0d", k), 32'(b4.op_ready), 32'h0);
         chk($sformatf("hold_lo_%0d", k), b4.lo, 32'hE);
      end
      @(negedge clk);
      chk("hold_end_ready", 32'(b4.op_ready), 32'h1);
      chk("hold_end_done", 32'(b4.done), 32'h1);
      chk("hold_end_lo", b4.lo, 32'h8E);
      chk("hold_end_hi", b4.hi, 32'h6);
      @(posedge clk);
      #1 b4.op_valid = 1'b0;
      @(negedge clk);
      chk("mtlo_lo", b4.lo, 32'hA5A5A5A5);
      chk("mtlo_hi", b4.hi, 32'h6);
      chk("mtlo_done", 32'(b4.done), 32'h1);
      @(negedge clk);
      chk("mtlo_done_drop", 32'(b4.done), 32'h0);
      b4.op_valid = 1'b1; b4.op_code = OP_DIV; b4.rs_data = 32'd50; b4.rt_data = 32'd3;
      @(posedge clk);
      #1 b4.op_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_ready", 32'(b4.op_ready), 32'h1);
      chk("abort_hi", b4.hi, 32'h0);
      chk("abort_lo", b4.lo, 32'h0);
      chk("abort_ena", 32'(b4.div_ena), 32'h0);
      nd = 0;
      for (int k = 0; k < 6; k++) begin
         if (b4.done) nd++;
         @(negedge clk);
      end
      chk("abort_no_done", 32'(nd), 32'h0);
      chk("abort_hi_late", b4.hi, 32'h0);
      b1.op_valid = 1'b1; b1.op_code = OP_DIV; b1.rs_data = 32'd20; b1.rt_data = 32'd3;
      @(posedge clk);
      #1 b1.rs_data = 32'hFFFFFFF7; b1.rt_data = 32'd4;
      @(negedge clk);
      chk("b2b_w1_ready", 32'(b1.op_ready), 32'h0);
      chk("b2b_w1_done", 32'(b1.done), 32'h0);
      @(negedge clk);
      chk("b2b_d1_done", 32'(b1.done), 32'h1);
      chk("b2b_d1_ready", 32'(b1.op_ready), 32'h1);
      chk("b2b_d1_lo", b1.lo, 32'h6);
      chk("b2b_d1_hi", b1.hi, 32'h2);
      @(posedge clk);
      #1 b1.op_valid = 1'b0;
      @(negedge clk);
      chk("b2b_w2_ready", 32'(b1.op_ready), 32'h0);
      chk("b2b_w2_done", 32'(b1.done), 32'h0);
      @(negedge clk);
      chk("b2b_d2_done", 32'(b1.done), 32'h1);
      chk("b2b_d2_lo", b1.lo, 32'hFFFFFFFE);
      chk("b2b_d2_hi", b1.hi, 32'hFFFFFFFF);
      chk("b2b_d2_sgn", 32'(b1.div_signed), 32'h1);
      @(negedge clk);
      chk("b2b_done_drop", 32'(b1.done), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
